// File: rtl/hilo_ctrl.sv
// HI/LO controller: launches MULT/MULTU on an external pipelined multiplier, waits out
// its latency while stalling the pipeline, then commits the product into HI/LO.
module hilo_ctrl #(
   parameter int MULT_LATENCY = 5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        op_valid,
   input  logic [2:0]  op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        flush,
   output logic        busy,
   output logic        done,
   output logic [31:0] mul_a,
   output logic [31:0] mul_b,
   output logic        mul_is_signed,
   input  logic [63:0] mul_hilo,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int CNT_W = $clog2(MULT_LATENCY + 1);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_MTHI  = 3'd3;
   localparam logic [2:0] OP_MTLO  = 3'd4;

   typedef enum logic {
      IDLE,
      MUL_WAIT
   } state_t;

   state_t           state, state_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic [31:0]      hi_next, lo_next;
   logic [31:0]      mul_a_next, mul_b_next;
   logic             mul_is_signed_next;
   logic             done_next;
   logic             busy_next;

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         cnt           <= '0;
         hi            <= '0;
         lo            <= '0;
         mul_a         <= '0;
         mul_b         <= '0;
         mul_is_signed <= 1'b0;
         done          <= 1'b0;
         busy          <= 1'b0;
      end else begin
         state         <= state_next;
         cnt           <= cnt_next;
         hi            <= hi_next;
         lo            <= lo_next;
         mul_a         <= mul_a_next;
         mul_b         <= mul_b_next;
         mul_is_signed <= mul_is_signed_next;
         done          <= done_next;
         busy          <= busy_next;
      end
   end

   // Operands are only reloaded on acceptance, so they stay stable for the whole wait.
   always_comb begin
      state_next         = state;
      cnt_next           = cnt;
      hi_next            = hi;
      lo_next            = lo;
      mul_a_next         = mul_a;
      mul_b_next         = mul_b;
      mul_is_signed_next = mul_is_signed;
      done_next          = 1'b0;

      case (state)
         IDLE: begin
            if (op_valid && !flush) begin
               case (op)
                  OP_MULT, OP_MULTU: begin
                     mul_a_next         = src_a;
                     mul_b_next         = src_b;
                     mul_is_signed_next = (op == OP_MULT);
                     cnt_next           = CNT_W'(MULT_LATENCY);
                     state_next         = MUL_WAIT;
                  end
                  OP_MTHI: hi_next = src_a;
                  OP_MTLO: lo_next = src_a;
                  default: ;
               endcase
            end
         end
         MUL_WAIT: begin
            if (flush) begin
               cnt_next   = '0;
               state_next = IDLE;
            end else begin
               cnt_next = cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  hi_next    = mul_hilo[63:32];
                  lo_next    = mul_hilo[31:0];
                  done_next  = 1'b1;
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase

      busy_next = (state_next == MUL_WAIT);
   end

endmodule

// File: tb/tb_hilo_ctrl.sv
// Self-checking bench for hilo_ctrl: models the multiplier as a pipeline and keeps a
// queue of expected {hi,lo} results that is drained whenever a commit is observed.
module tb_hilo_ctrl;

   localparam int L = 5;

   localparam logic [2:0] OP_NOP   = 3'd0;
   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_MTHI  = 3'd3;
   localparam logic [2:0] OP_MTLO  = 3'd4;

   logic        clk = 1'b0;
   logic        reset;
   logic        op_valid;
   logic [2:0]  op;
   logic [31:0] src_a, src_b;
   logic        flush;
   logic        busy, done;
   logic [31:0] mul_a, mul_b;
   logic        mul_is_signed;
   logic [63:0] mul_hilo;
   logic [31:0] hi, lo;

   int num_checks = 0;
   int num_errors = 0;
   logic [63:0] exp_q[$];

   hilo_ctrl #(.MULT_LATENCY(L)) dut (
      .clk(clk), .reset(reset), .op_valid(op_valid), .op(op),
      .src_a(src_a), .src_b(src_b), .flush(flush),
      .busy(busy), .done(done), .mul_a(mul_a), .mul_b(mul_b),
      .mul_is_signed(mul_is_signed), .mul_hilo(mul_hilo), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] model_product(input logic [31:0] a, input logic [31:0] b,
                                                 input logic is_signed);
      logic [63:0] xa, xb;
      xa = is_signed ? {{32{a[31]}}, a} : {32'd0, a};
      xb = is_signed ? {{32{b[31]}}, b} : {32'd0, b};
      return xa * xb;
   endfunction

   // Multiplier model: product of the held operands becomes visible after L-1 edges.
   logic [63:0] comb_prod;
   logic [63:0] stage [L-1];
   assign comb_prod = model_product(mul_a, mul_b, mul_is_signed);
   always_ff @(posedge clk) begin
      stage[0] <= comb_prod;
      for (int i = 1; i < L - 1; i++) stage[i] <= stage[i-1];
   end
   assign mul_hilo = stage[L-2];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      num_checks++;
      if (actual !== expected) begin
         num_errors++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
      end
   endtask

   // Presents one op for a single cycle; multiplies optionally push their expected result.
   task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                input bit push);
      op_valid = 1'b1;
      op       = o;
      src_a    = a;
      src_b    = b;
      if (push) exp_q.push_back(model_product(a, b, o == OP_MULT));
      tick();
      op_valid = 1'b0;
      op       = OP_NOP;
   endtask

   task automatic wait_commit(input string tag, input logic exp_signed);
      int n;
      logic [63:0] exp;
      n = 0;
      while (busy && n < 50) begin
         checkOutput({tag, "_done_low"}, 64'(done), 64'd0);
         checkOutput({tag, "_signed"}, 64'(mul_is_signed), 64'(exp_signed));
         tick();
         n++;
      end
      checkOutput({tag, "_busy_cycles"}, 64'(n), 64'(L));
      checkOutput({tag, "_done"}, 64'(done), 64'd1);
      if (exp_q.size() == 0) begin
         checkOutput({tag, "_queue_empty"}, 64'd1, 64'd0);
      end else begin
         exp = exp_q.pop_front();
         checkOutput({tag, "_hilo"}, {hi, lo}, exp);
      end
   endtask

   logic [31:0] hold_hi, hold_lo;

   initial begin
      reset = 1'b1; op_valid = 1'b0; op = OP_NOP; src_a = '0; src_b = '0; flush = 1'b0;
      tick(); tick();
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_done", 64'(done), 64'd0);
      checkOutput("rst_hilo", {hi, lo}, 64'd0);
      checkOutput("rst_mul_ab", {mul_a, mul_b}, 64'd0);
      checkOutput("rst_signed", 64'(mul_is_signed), 64'd0);
      reset = 1'b0;
      tick();

      // 1: signed -1 * 2
      applyStimulus(OP_MULT, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1);
      wait_commit("t1", 1'b1);
      checkOutput("t1_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);
      tick();
      checkOutput("t1_done_pulse", 64'(done), 64'd0);

      // 2: unsigned same operands
      applyStimulus(OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1);
      wait_commit("t2", 1'b0);
      checkOutput("t2_const", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
      tick();

      // 3: back-to-back, second multiply issued in the done cycle
      applyStimulus(OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b1);
      wait_commit("t3a", 1'b1);
      applyStimulus(OP_MULT, 32'd3, 32'hFFFF_FFFC, 1'b1);
      wait_commit("t3b", 1'b1);
      checkOutput("t3b_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF4);
      tick();

      // 4: MTHI then MTLO on consecutive cycles
      applyStimulus(OP_MTHI, 32'h1234_5678, 32'd0, 1'b0);
      checkOutput("t4_hi", 64'(hi), 64'h1234_5678);
      checkOutput("t4_lo_kept", 64'(lo), 64'hFFFF_FFF4);
      checkOutput("t4_busy_hi", 64'(busy), 64'd0);
      applyStimulus(OP_MTLO, 32'h9ABC_DEF0, 32'd0, 1'b0);
      checkOutput("t4_lo", 64'(lo), 64'h9ABC_DEF0);
      checkOutput("t4_busy_lo", 64'(busy), 64'd0);

      // 5: flush in wait cycle 3, MTLO presented while busy is ignored
      hold_hi = 32'h1234_5678; hold_lo = 32'h9ABC_DEF0;
      applyStimulus(OP_MULT, 32'd5, 32'd7, 1'b0);
      checkOutput("t5_busy", 64'(busy), 64'd1);
      op_valid = 1'b1; op = OP_MTLO; src_a = 32'hDEAD_BEEF;
      tick(); tick();
      op_valid = 1'b0; op = OP_NOP; flush = 1'b1;
      tick();
      flush = 1'b0;
      checkOutput("t5_busy_after_flush", 64'(busy), 64'd0);
      for (int i = 0; i < L + 2; i++) begin
         checkOutput("t5_no_done", 64'(done), 64'd0);
         tick();
      end
      checkOutput("t5_hilo_kept", {hi, lo}, {hold_hi, hold_lo});

      // flush exactly on the final wait cycle still suppresses the commit
      applyStimulus(OP_MULTU, 32'd100, 32'd100, 1'b0);
      for (int i = 1; i < L; i++) tick();
      checkOutput("fl_last_busy", 64'(busy), 64'd1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checkOutput("fl_last_busy_low", 64'(busy), 64'd0);
      checkOutput("fl_last_no_done", 64'(done), 64'd0);
      checkOutput("fl_last_hilo", {hi, lo}, {hold_hi, hold_lo});

      // flush in IDLE blocks acceptance; ops 5-7 are ignored
      flush = 1'b1;
      applyStimulus(OP_MTHI, 32'hAAAA_AAAA, 32'd0, 1'b0);
      flush = 1'b0;
      checkOutput("idle_flush_hi", 64'(hi), 64'(hold_hi));
      applyStimulus(3'd5, 32'hBBBB_BBBB, 32'd0, 1'b0);
      applyStimulus(3'd7, 32'hCCCC_CCCC, 32'd0, 1'b0);
      checkOutput("op_ignored_busy", 64'(busy), 64'd0);
      checkOutput("op_ignored_hilo", {hi, lo}, {hold_hi, hold_lo});

      // 6: reset in wait cycle 2, then a fresh MULTU
      applyStimulus(OP_MULT, 32'd9, 32'd9, 1'b0);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checkOutput("t6_hilo", {hi, lo}, 64'd0);
      checkOutput("t6_busy", 64'(busy), 64'd0);
      checkOutput("t6_done", 64'(done), 64'd0);
      checkOutput("t6_mul_ab", {mul_a, mul_b}, 64'd0);
      tick();
      applyStimulus(OP_MULTU, 32'd7, 32'd6, 1'b1);
      wait_commit("t6", 1'b0);
      checkOutput("t6_lo42", 64'(lo), 64'd42);
      tick();

      checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
      $finish;
   end

endmodule
